// File: rtl/pc_fetch_predictor.sv
// Fetch-stage PC register with a direct-mapped BTB of 2-bit saturating counters.
// Lookup is combinational on PCF; training arrives from execute one entry per cycle.
module pc_fetch_predictor #(
  parameter int          ENTRIES  = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  input  logic        redirect_e,
  input  logic [31:0] redirect_pc_e,
  input  logic        update_e,
  input  logic [31:0] update_pc_e,
  input  logic        update_taken_e,
  input  logic [31:0] update_target_e,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        pred_taken_f,
  output logic [31:0] pred_target_f
);
  localparam int IW = $clog2(ENTRIES);
  localparam int TW = 30 - IW;

  // PCs and targets are word addresses internally, so bits [1:0] are zero by construction.
  logic [29:0]                   pc_q, pc_d;
  logic [ENTRIES-1:0]            valid_q, valid_d;
  logic [ENTRIES-1:0][TW-1:0]    tag_q, tag_d;
  logic [ENTRIES-1:0][29:0]      target_q, target_d;
  logic [ENTRIES-1:0][1:0]       ctr_q, ctr_d;

  logic [IW-1:0] idx_f, upd_idx;
  logic          hit_f, upd_hit;
  logic          unused_lsbs;

  assign unused_lsbs = ^{redirect_pc_e[1:0], update_pc_e[1:0], update_target_e[1:0]};

  assign idx_f         = pc_q[IW-1:0];
  assign hit_f         = valid_q[idx_f] && (tag_q[idx_f] == pc_q[29:IW]);
  assign PCF           = {pc_q, 2'b00};
  assign PCPlus4F      = {pc_q + 30'd1, 2'b00};
  assign pred_taken_f  = hit_f && ctr_q[idx_f][1];
  assign pred_target_f = hit_f ? {target_q[idx_f], 2'b00} : PCPlus4F;

  assign upd_idx = update_pc_e[IW+1:2];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == update_pc_e[31:IW+2]);

  always_comb begin
    pc_d = pc_q + 30'd1;
    if (redirect_e)        pc_d = redirect_pc_e[31:2];
    else if (stall_f)      pc_d = pc_q;
    else if (pred_taken_f) pc_d = target_q[idx_f];
  end

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (update_e) begin
      if (upd_hit) begin
        if (update_taken_e) begin
          if (ctr_q[upd_idx] != 2'b11) ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
          target_d[upd_idx] = update_target_e[31:2];
        end else if (ctr_q[upd_idx] != 2'b00) begin
          ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
        end
      end else if (update_taken_e) begin
        // Miss on a taken branch: evict whatever aliases here, start weakly taken.
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = update_pc_e[31:IW+2];
        target_d[upd_idx] = update_target_e[31:2];
        ctr_d[upd_idx]    = 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC[31:2];
      valid_q  <= '0;
      tag_q    <= '0;
      target_q <= '0;
      ctr_q    <= {ENTRIES{2'b01}};
    end else begin
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end
endmodule

// File: doc/pc_fetch_predictor.md
PC_FETCH_PREDICTOR -- requirements
Module: pc_fetch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, meaning number of predictor entries (power of two, 4..64).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 stall_f  input  1  hold PCF (data-hazard stall, same cycle as stall_d downstream).
REQ-007 redirect_e  input  1  misprediction correction from execute.
REQ-008 redirect_pc_e  input  32  corrected fetch address.
REQ-009 update_e  input  1  a branch/jal/jalr resolved in execute this cycle.
REQ-010 update_pc_e  input  32  PC of the resolved instruction.
REQ-011 update_taken_e  input  1  resolved direction.
REQ-012 update_target_e  input  32  resolved target address.
REQ-013 PCF  output  32  current fetch PC (registered).
REQ-014 PCPlus4F  output  32  PCF+4.
REQ-015 pred_taken_f  output  1  prediction for PCF.
REQ-016 pred_target_f  output  32  predicted target for PCF.

Function
REQ-017 SHALL hold ENTRIES entries of {valid, tag, target[31:0], ctr[1:0]}; IW = log2(ENTRIES); index = PC[IW+1:2]; tag = PC[31:IW+2].
REQ-018 Lookup SHALL be combinational on PCF: hit = valid & tag match; pred_taken_f = hit & ctr[1]; pred_target_f = entry target when hit, else PCPlus4F.
REQ-019 PCPlus4F SHALL equal PCF+4 modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-020 Next-PC priority SHALL be: reset > redirect_e > stall_f > pred_taken_f -> pred_target_f > PCPlus4F.
REQ-021 redirect_e SHALL override stall_f; PCF = redirect_pc_e on the next edge.
REQ-022 PCF[1:0] SHALL always be 0; bits [1:0] of redirect_pc_e and update_target_e are written as 0.
REQ-023 On update_e with a hit at the update_pc_e index, the counter SHALL increment when taken and decrement when not taken, saturating at 2'b11 and 2'b00.
REQ-024 On update_e with a hit and taken, the target SHALL be overwritten with update_target_e.
REQ-025 On update_e with a miss and taken, the entry SHALL be allocated: valid=1, tag, target, ctr=2'b10 (weakly taken), replacing any existing entry.
REQ-026 On update_e with a miss and not taken, the table SHALL NOT change.
REQ-027 update_e SHALL be honoured regardless of stall_f and redirect_e.
REQ-028 A lookup and update of the same entry in the same cycle SHALL see the pre-update contents; the new contents are visible from the next cycle.
REQ-029 The prediction SHALL have zero latency; the predicted target is fetched one cycle after PCF presents the branch.

Reset
REQ-030 On reset: PCF = RESET_PC, all valid = 0, all ctr = 2'b01, targets and tags = 0.
REQ-031 During reset, update_e, redirect_e and stall_f SHALL be ignored.
REQ-032 After reset: pred_taken_f = 0, pred_target_f = RESET_PC+4, PCPlus4F = RESET_PC+4.
REQ-033 Reset asserted mid-stream SHALL take effect on the next edge and discard any same-cycle update.

Verification
REQ-034 Reset, then 3 cycles free-running -> PCF = 0, 4, 8, 12; pred_taken_f = 0 throughout.
REQ-035 update_e with pc=0x40, taken=1, target=0x100; PCF later reaches 0x40 -> pred_taken_f = 1, next PCF = 0x100.
REQ-036 Four not-taken updates at 0x40 after REQ-035 -> ctr goes 10->01->00->00; pred_taken_f = 0 at 0x40 after the first.
REQ-037 stall_f = 1 and redirect_e = 1 with redirect_pc_e = 0x200 in the same cycle -> PCF = 0x200.
REQ-038 stall_f = 1 for 3 cycles at PCF = 0x10 -> PCF holds 0x10; a concurrent update_e is still written.
REQ-039 Alias test: pc=0x40 allocated, then a taken update at pc=0x40+4*ENTRIES -> replaces the entry; lookup at 0x40 misses.
